// File: rtl/ram_ctrl_if.sv
// CPU data-bus bundle for ram_ctrl: request/acknowledge handshake plus read data and busy.
// With RAM_PARITY_EN defined the bundle also carries perr_inject and perr.
interface ram_ctrl_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  rdata;
    logic              ack;
    logic              busy;
`ifdef RAM_PARITY_EN
    logic              perr_inject;
    logic              perr;

    modport master (output req, we, addr, wdata, perr_inject, input rdata, ack, busy, perr);
    modport slave  (input req, we, addr, wdata, perr_inject, output rdata, ack, busy, perr);
`else
    modport master (output req, we, addr, wdata, input rdata, ack, busy);
    modport slave  (input req, we, addr, wdata, output rdata, ack, busy);
`endif
endinterface

// File: rtl/ram_ctrl.sv
// Single-port data RAM with req/ack handshake, WAIT extra cycles per access and a clear sweep after reset.
// Optional RAM_PARITY_EN adds one even-parity bit per word, perr_inject on writes and perr on reads.
module ram_ctrl #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int WAIT   = 1
) (
    input  logic       CPUclk,
    input  logic       rst_n,
    ram_ctrl_if.slave  bus
);
`ifdef RAM_PARITY_EN
    localparam int MEM_W = WIDTH + 1;
`else
    localparam int MEM_W = WIDTH;
`endif
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   RANGE     = (ADDR_W + 1)'(DEPTH);
    localparam logic [2:0]        WAIT_L    = 3'(WAIT);

    typedef enum logic [1:0] {INIT, IDLE, WAITST, RESP} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic [2:0]        wait_reg, wait_next;
    logic              latch;

    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [WIDTH-1:0]  wdata_reg;
    logic [WIDTH-1:0]  rdata_reg;
    logic              ack_reg;
    logic              busy_reg;

    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [WIDTH-1:0]  acc_wdata;
    logic              access;
    logic              in_range;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [MEM_W-1:0]  mem_wword;
    logic [MEM_W-1:0]  wr_word;

    logic [MEM_W-1:0]  mem [DEPTH];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wait_next  = wait_reg;
        latch      = 1'b0;
        case (state_reg)
            INIT: begin
                cnt_next = cnt_reg + ADDR_W'(1);
                if (cnt_reg == LAST_ADDR) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            IDLE: begin
                if (bus.req) begin
                    latch = 1'b1;
                    if (WAIT == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAITST;
                        wait_next  = WAIT_L;
                    end
                end
            end
            WAITST: begin
                wait_next = wait_reg - 3'd1;
                if (wait_reg == 3'd1) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = INIT;
        endcase
    end

    // With WAIT=0 the access edge is the sampling edge, so the live bus values are used there.
    assign acc_we    = (state_reg == IDLE) ? bus.we    : we_reg;
    assign acc_addr  = (state_reg == IDLE) ? bus.addr  : addr_reg;
    assign acc_wdata = (state_reg == IDLE) ? bus.wdata : wdata_reg;
    assign access    = (state_next == RESP) && (state_reg != RESP);
    assign in_range  = ({1'b0, acc_addr} < RANGE);

`ifdef RAM_PARITY_EN
    logic inj_reg;
    logic acc_inj;
    logic perr_reg;

    assign acc_inj  = (state_reg == IDLE) ? bus.perr_inject : inj_reg;
    assign wr_word  = {(^acc_wdata) ^ acc_inj, acc_wdata};
    assign bus.perr = perr_reg;
`else
    assign wr_word  = acc_wdata;
`endif

    assign mem_we    = (state_reg == INIT) || (access && acc_we && in_range);
    assign mem_waddr = (state_reg == INIT) ? cnt_reg : acc_addr;
    assign mem_wword = (state_reg == INIT) ? '0 : wr_word;

    always_ff @(posedge CPUclk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wword;
        end
    end

    always_ff @(posedge CPUclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= INIT;
            cnt_reg   <= '0;
            wait_reg  <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            ack_reg   <= 1'b0;
            busy_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            wait_reg  <= wait_next;
            ack_reg   <= access;
            busy_reg  <= (state_next == INIT);
            if (latch) begin
                we_reg    <= bus.we;
                addr_reg  <= bus.addr;
                wdata_reg <= bus.wdata;
            end
            if (access && !acc_we) begin
                rdata_reg <= in_range ? mem[acc_addr][WIDTH-1:0] : '0;
            end
        end
    end

`ifdef RAM_PARITY_EN
    // Even parity over data plus stored bit: a nonzero XOR means the word disagrees with its parity.
    always_ff @(posedge CPUclk or negedge rst_n) begin
        if (!rst_n) begin
            inj_reg  <= 1'b0;
            perr_reg <= 1'b0;
        end else begin
            if (latch) begin
                inj_reg <= bus.perr_inject;
            end
            if (access && !acc_we) begin
                perr_reg <= in_range ? (^mem[acc_addr]) : 1'b0;
            end
        end
    end
`endif

    assign bus.rdata = rdata_reg;
    assign bus.ack   = ack_reg;
    assign bus.busy  = busy_reg;
endmodule
